// File: rtl/hazard_pkg.sv
// Shared constants and types for the decode-stage register hazard scoreboard.
package hazard_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REG_NUM    = 8;
    localparam int unsigned ADDR_WIDTH = 3;
    localparam int unsigned CNT_WIDTH  = 2;
    localparam int unsigned CNT_MAX    = (1 << CNT_WIDTH) - 1;

    // Why decode is held this cycle; IO ownership outranks every hazard.
    typedef enum logic [2:0] {
        NONE    = 3'd0,
        RAW1    = 3'd1,
        RAW2    = 3'd2,
        WAW_SAT = 3'd3,
        IO      = 3'd4
    } stall_reason_e;

endpackage

// File: rtl/pending_counter.sv
// In-flight write counter for one register, with an underflow event on a stray writeback.
module pending_counter
    import hazard_pkg::*;
#(
    parameter int unsigned CNTWIDTH = CNT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    output logic [CNTWIDTH-1:0] cnt,
    output logic                nonzero,
    output logic                underflow_c
);

    logic [CNTWIDTH-1:0] cnt_next;

    // Simultaneous issue and writeback cancel; the issue path never overflows.
    always_comb begin
        cnt_next    = cnt;
        underflow_c = 1'b0;
        unique case ({inc, dec})
            2'b10: cnt_next = cnt + CNTWIDTH'(1);
            2'b01: begin
                if (cnt == '0) begin
                    underflow_c = 1'b1;
                end else begin
                    cnt_next = cnt - CNTWIDTH'(1);
                end
            end
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            nonzero <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            nonzero <= (cnt_next != '0);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage register hazard controller: tracks in-flight writes and stalls
// decode on RAW hazards, pending-count saturation or IO ownership of the regfile.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REGNUM       = REG_NUM,
    parameter int unsigned ADDRESSWIDTH = ADDR_WIDTH,
    parameter int unsigned CNTWIDTH     = CNT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    issueValid,
    input  logic                    usesReg1,
    input  logic                    usesReg2,
    input  logic                    writesDest,
    input  logic [ADDRESSWIDTH-1:0] reg1Address,
    input  logic [ADDRESSWIDTH-1:0] reg2Address,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddress,
    input  logic                    wbValid,
    input  logic [ADDRESSWIDTH-1:0] wbAddress,
    input  logic                    startIO,
    output logic                    stall,
    output logic                    issueFire,
    output logic [REGNUM-1:0]       pendingMask,
    output logic [15:0]             stallCount,
    output logic                    wbUnderflow
);

    localparam logic [CNTWIDTH-1:0] CNT_FULL = {CNTWIDTH{1'b1}};

    logic [CNTWIDTH-1:0] cnt [REGNUM];
    logic [CNTWIDTH-1:0] eff [REGNUM];
    logic [REGNUM-1:0]   rd1_sel, rd2_sel, dst_sel, wb_sel;
    logic [REGNUM-1:0]   inc_sel, eff_nz, eff_full, udf;
    logic                raw1, raw2, waw_sat;
    stall_reason_e       reason;

    // Per-register decode, writeback-forwarded pending count and counter.
    for (genvar r = 0; r < REGNUM; r++) begin : g_reg
        assign rd1_sel[r] = (reg1Address == ADDRESSWIDTH'(r));
        assign rd2_sel[r] = (reg2Address == ADDRESSWIDTH'(r));
        assign dst_sel[r] = (regDestinationAddress == ADDRESSWIDTH'(r));
        assign wb_sel[r]  = wbValid && (wbAddress == ADDRESSWIDTH'(r));

        // A stray writeback to an idle register must not fake a hazard.
        assign eff[r]      = (wb_sel[r] && (cnt[r] != '0)) ? cnt[r] - CNTWIDTH'(1) : cnt[r];
        assign eff_nz[r]   = (eff[r] != '0);
        assign eff_full[r] = (eff[r] == CNT_FULL);
        assign inc_sel[r]  = issueFire && writesDest && dst_sel[r];

        pending_counter #(
            .CNTWIDTH (CNTWIDTH)
        ) u_cnt (
            .clk         (clock),
            .rst_n       (reset),
            .inc         (inc_sel[r]),
            .dec         (wb_sel[r]),
            .cnt         (cnt[r]),
            .nonzero     (pendingMask[r]),
            .underflow_c (udf[r])
        );
    end

    assign raw1    = usesReg1 && |(rd1_sel & eff_nz);
    assign raw2    = usesReg2 && |(rd2_sel & eff_nz);
    assign waw_sat = writesDest && |(dst_sel & eff_full);

    always_comb begin
        reason = NONE;
        if (issueValid) begin
            if (startIO)      reason = IO;
            else if (raw1)    reason = RAW1;
            else if (raw2)    reason = RAW2;
            else if (waw_sat) reason = WAW_SAT;
        end
    end

    assign stall     = (reason != NONE);
    assign issueFire = issueValid && !stall;

    // Saturating stall statistics and sticky underflow error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCount  <= '0;
            wbUnderflow <= 1'b0;
        end else begin
            if (stall && (stallCount != 16'hFFFF)) begin
                stallCount <= stallCount + 16'd1;
            end
            wbUnderflow <= wbUnderflow | (|udf);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand sequences for reset and self-dependence.
module tb_hazard_scoreboard;

    logic       clock;
    logic       reset;
    logic       issueValid, usesReg1, usesReg2, writesDest;
    logic [2:0] reg1Address, reg2Address, regDestinationAddress;
    logic       wbValid;
    logic [2:0] wbAddress;
    logic       startIO;
    logic       stall, issueFire;
    logic [7:0] pendingMask;
    logic [15:0] stallCount;
    logic       wbUnderflow;

    hazard_scoreboard dut (
        .clock                 (clock),
        .reset                 (reset),
        .issueValid            (issueValid),
        .usesReg1              (usesReg1),
        .usesReg2              (usesReg2),
        .writesDest            (writesDest),
        .reg1Address           (reg1Address),
        .reg2Address           (reg2Address),
        .regDestinationAddress (regDestinationAddress),
        .wbValid               (wbValid),
        .wbAddress             (wbAddress),
        .startIO               (startIO),
        .stall                 (stall),
        .issueFire             (issueFire),
        .pendingMask           (pendingMask),
        .stallCount            (stallCount),
        .wbUnderflow           (wbUnderflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit       iv, u1, u2, wd;
        bit [2:0] a1, a2, ad;
        bit       wbv;
        bit [2:0] wba;
        bit       sio;
        bit       st, fi;
        bit [7:0] mask;
        bit [15:0] scnt;
        bit       udf;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(int iv, int u1, int u2, int wd, int a1, int a2, int ad,
                                int wbv, int wba, int sio, int st, int fi, int mask,
                                int scnt, int udf);
        vec_t v;
        v.iv = 1'(iv);   v.u1 = 1'(u1);   v.u2 = 1'(u2);   v.wd = 1'(wd);
        v.a1 = 3'(a1);   v.a2 = 3'(a2);   v.ad = 3'(ad);
        v.wbv = 1'(wbv); v.wba = 3'(wba); v.sio = 1'(sio);
        v.st = 1'(st);   v.fi = 1'(fi);   v.mask = 8'(mask);
        v.scnt = 16'(scnt); v.udf = 1'(udf);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issueValid = v.iv;  usesReg1 = v.u1;  usesReg2 = v.u2;  writesDest = v.wd;
        reg1Address = v.a1; reg2Address = v.a2; regDestinationAddress = v.ad;
        wbValid = v.wbv;    wbAddress = v.wba;  startIO = v.sio;
    endtask

    initial begin
        //                iv u1 u2 wd a1 a2 ad wbv wba sio  st fi mask  scnt udf
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 'h00, 0, 0);
        // RAW on r2 resolved by same-cycle writeback
        vecs[1]  = mk(1, 0, 0, 1, 0, 0, 2, 0, 0, 0,  0, 1, 'h04, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 2, 0, 0, 0, 0, 0,  1, 0, 'h04, 1, 0);
        vecs[3]  = mk(1, 0, 1, 0, 0, 2, 0, 0, 0, 0,  1, 0, 'h04, 2, 0);
        vecs[4]  = mk(1, 1, 0, 0, 2, 0, 0, 1, 2, 0,  0, 1, 'h00, 2, 0);
        // same-cycle inc/dec on r5
        vecs[5]  = mk(1, 0, 0, 1, 0, 0, 5, 0, 0, 0,  0, 1, 'h20, 2, 0);
        vecs[6]  = mk(1, 0, 0, 1, 0, 0, 5, 1, 5, 0,  0, 1, 'h20, 2, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 'h00, 2, 0);
        // saturation of r1
        vecs[8]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0,  0, 1, 'h02, 2, 0);
        vecs[9]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0,  0, 1, 'h02, 2, 0);
        vecs[10] = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0,  0, 1, 'h02, 2, 0);
        vecs[11] = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0,  1, 0, 'h02, 3, 0);
        vecs[12] = mk(1, 1, 0, 1, 4, 0, 0, 0, 0, 0,  0, 1, 'h03, 3, 0);
        vecs[13] = mk(1, 0, 0, 1, 0, 0, 1, 1, 1, 0,  0, 1, 'h03, 3, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 'h03, 3, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 'h03, 3, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 'h01, 3, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 'h00, 3, 0);
        // startIO holds a hazard-free writer for 4 cycles
        vecs[18] = mk(1, 1, 0, 1, 6, 0, 6, 0, 0, 1,  1, 0, 'h00, 4, 0);
        vecs[19] = mk(1, 1, 0, 1, 6, 0, 6, 0, 0, 1,  1, 0, 'h00, 5, 0);
        vecs[20] = mk(1, 1, 0, 1, 6, 0, 6, 0, 0, 1,  1, 0, 'h00, 6, 0);
        vecs[21] = mk(1, 1, 0, 1, 6, 0, 6, 0, 0, 1,  1, 0, 'h00, 7, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 'h00, 7, 0);
        // underflow on r7 is sticky
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 'h00, 7, 1);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 'h00, 7, 1);
        vecs[25] = mk(1, 1, 0, 1, 7, 0, 3, 0, 0, 0,  0, 1, 'h08, 7, 1);
        vecs[26] = mk(1, 0, 0, 1, 0, 0, 3, 0, 0, 0,  0, 1, 'h08, 7, 1);

        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk("rst_mask", 32'(pendingMask), 32'h0);
        chk("rst_scnt", 32'(stallCount), 32'h0);
        chk("rst_udf",  32'(wbUnderflow), 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].st));
            chk($sformatf("v%0d_fire", i),  32'(issueFire), 32'(vecs[i].fi));
            @(posedge clock); #1;
            chk($sformatf("v%0d_mask", i), 32'(pendingMask), 32'(vecs[i].mask));
            chk($sformatf("v%0d_scnt", i), 32'(stallCount), 32'(vecs[i].scnt));
            chk($sformatf("v%0d_udf", i),  32'(wbUnderflow), 32'(vecs[i].udf));
        end

        // Async reset mid-run with cnt[3]=2: everything clears without a clock edge.
        drive(mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_rst_stall", 32'(stall), 32'h1);
        reset = 1'b0;
        #1;
        chk("arst_mask",  32'(pendingMask), 32'h0);
        chk("arst_scnt",  32'(stallCount), 32'h0);
        chk("arst_udf",   32'(wbUnderflow), 32'h0);
        chk("arst_stall", 32'(stall), 32'h0);
        chk("arst_fire",  32'(issueFire), 32'h1);
        startIO = 1'b1;
        #1;
        chk("arst_io_stall", 32'(stall), 32'h1);
        chk("arst_io_fire",  32'(issueFire), 32'h0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_mask", 32'(pendingMask), 32'h0);

        // Stale writeback from before reset raises underflow.
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;
        chk("stale_wb_udf",  32'(wbUnderflow), 32'h1);
        chk("stale_wb_mask", 32'(pendingMask), 32'h0);

        // Destination equal to source: no self-hazard, but the next reader waits.
        drive(mk(1, 1, 0, 1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("self_fire", 32'(issueFire), 32'h1);
        @(posedge clock); #1;
        chk("self_mask", 32'(pendingMask), 32'h04);
        chk("self_next_stall", 32'(stall), 32'h1);
        @(posedge clock); #1;
        chk("self_scnt", 32'(stallCount), 32'h1);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clock); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-hazard controller for the decode stage. It tracks in-flight writes to every regfile register, decides each cycle whether the instruction in decode may issue, and holds decode (stall) on read-after-write hazards, pending-count saturation, or while the regfile is owned by the IO path (startIO). It sits beside the decode stage, takes source/destination addresses from it and writeback events from the last pipeline stage, and drives the pipeline stall line.

## Interface
- WIDTH, 32: datapath width (kept for package consistency; unused internally)
- REGNUM, 8: number of regfile registers tracked
- ADDRESSWIDTH, 3: register address width
- CNTWIDTH, 2: per-register pending-write counter width (max in-flight writes = 2^CNTWIDTH-1)
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- issueValid  input  1  decode holds a valid instruction
- usesReg1 / usesReg2  input  1 each  instruction reads reg1Address / reg2Address
- writesDest  input  1  instruction will write regDestinationAddress
- reg1Address, reg2Address, regDestinationAddress  input  ADDRESSWIDTH each  decode-stage addresses
- wbValid  input  1  writeback stage writes the regfile this cycle
- wbAddress  input  ADDRESSWIDTH  writeback destination
- startIO  input  1  IO owns the regfile; no issue permitted
- stall  output  1  hold decode/fetch this cycle (combinational)
- issueFire  output  1  issueValid & !stall (combinational)
- pendingMask  output  REGNUM  bit r = counter r nonzero (registered)
- stallCount  output  16  saturating count of stalled valid cycles
- wbUnderflow  output  1  sticky error: writeback to register with no pending write

## Operation
- State: REGNUM counters cnt[r] (CNTWIDTH bits), stallCount, wbUnderflow.
- Effective pending: eff[r] = cnt[r] - (wbValid && wbAddress==r). The regfile writes on the falling edge, so a same-cycle writeback is readable by decode; eff, not cnt, is used for RAW checks.
- Hazard terms (only when issueValid):
  - raw1 = usesReg1 && eff[reg1Address] != 0; raw2 likewise for reg2Address.
  - waw_sat = writesDest && eff[regDestinationAddress] == 2^CNTWIDTH-1.
- stall = issueValid && (raw1 | raw2 | waw_sat | startIO). stall is 0 when issueValid=0.
- Counter update per register r, per edge:
  - inc = issueFire && writesDest && regDestinationAddress==r; dec = wbValid && wbAddress==r.
  - inc&dec: unchanged. inc only: +1 (never overflows, guarded by waw_sat). dec only: -1 if cnt>0; if cnt==0, hold at 0 and set wbUnderflow.
- stallCount increments when stall=1, saturates at 16'hFFFF, never wraps.
- wbUnderflow clears only on reset.
- Destination equal to a source: RAW check uses the pre-issue eff value; no self-hazard.

## Timing
- Reset (reset=0, asynchronous): all cnt=0, pendingMask=0, stallCount=0, wbUnderflow=0. stall/issueFire follow inputs combinationally (stall=startIO&&issueValid with counters clear).
- Reset asserted mid-operation discards all pending state; in-flight writebacks after release raise wbUnderflow (expected; the pipeline must be flushed with reset).
- stall/issueFire: zero-cycle latency from inputs and current state.
- Counter/pendingMask: update visible the cycle after the issue/writeback edge.
- Issue-to-unstall: a dependent instruction issues in the same cycle its producer's wbValid is asserted.
- startIO has priority; it overrides all hazard results, no counter changes other than writebacks.

## Structure
- Package hazard_pkg: CNTWIDTH default, CNT_MAX constant, stall-reason enum (NONE, RAW1, RAW2, WAW_SAT, IO) used for debug tracing.
- One sub-module: pending_counter (single register's saturating up/down counter with underflow flag), instantiated REGNUM times via generate.
- Top holds address decoders, hazard logic, stallCount.

## Test plan
- Reset: drive reset=0 mid-run with cnt[3]=2 -> pendingMask=0, stallCount=0 immediately, no clock required.
- RAW: issue write r2 (cycle 0), next cycle instruction reads r2 -> stall=1 until wbValid,wbAddress=2, that cycle stall=0, issueFire=1; stallCount increments by exact stalled cycles.
- Same-cycle inc/dec: cnt[5]=1, issue write r5 with wbValid to r5 -> cnt[5] stays 1, pendingMask[5]=1.
- Saturation: three issues writing r1 with no writeback -> fourth write to r1 stalls (waw_sat), read of r4 unaffected; one writeback to r1 -> issue resumes.
- startIO: hazard-free instruction with startIO=1 for 4 cycles -> stall=1 for 4 cycles, stallCount=4, counters unchanged.
- Underflow: wbValid to r7 with cnt[7]=0 -> cnt[7]=0, wbUnderflow=1 and stays set until reset.
